// File: rtl/ack_bus_arbiter_rr_if.sv
// Ack-bus request/grant bundle between the ack requesters and the arbiter.
// The arbiter takes the master modport and the requester side takes the slave modport.
interface ack_bus_arbiter_rr_if #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
);
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] grant;
    logic [ID_W-1:0]    winner_id;
    logic               ack_event;
    logic               timeout_err;

    modport master (
        input  req,
        output grant,
        output winner_id,
        output ack_event,
        output timeout_err
    );

    modport slave (
        output req,
        input  grant,
        input  winner_id,
        input  ack_event,
        input  timeout_err
    );
endinterface

// File: rtl/ack_bus_arbiter_rr.sv
// Registered ack-bus arbiter: fixed-priority or round-robin, grant held for the whole
// transfer, with a hold-timeout watchdog that masks a stuck requester until it drops req.
module ack_bus_arbiter_rr #(
    parameter int NUM_SRC  = 4,
    parameter int ID_W     = 2,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ack_bus_arbiter_rr_if.master  bus
);
    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]         state;
    logic [NUM_SRC-1:0] grant_q;
    logic [NUM_SRC-1:0] stall_mask;
    logic [ID_W-1:0]    last;
    logic [CNT_W-1:0]   hold_cnt;
    logic               timeout_q;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] pick_onehot;
    logic [ID_W-1:0]    pick_id;
    logic               found;
    int                 idx;

    assign eligible = bus.req & ~stall_mask;

    // Winner search: fixed mode scans upward from 0, RR mode scans upward from last+1 with wrap.
    always_comb begin
        found       = 1'b0;
        pick_id     = '0;
        pick_onehot = '0;
        idx         = 0;
        for (int off = 0; off < NUM_SRC; off++) begin
            if (RR_MODE != 0) begin
                idx = int'(last) + 1 + off;
                if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            end else begin
                idx = off;
            end
            if (!found && eligible[idx]) begin
                found            = 1'b1;
                pick_id          = ID_W'(idx);
                pick_onehot[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            stall_mask <= '0;
            last       <= ID_W'(NUM_SRC - 1);
            hold_cnt   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q  <= 1'b0;
            stall_mask <= stall_mask & bus.req;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant_q  <= pick_onehot;
                        last     <= pick_id;
                        hold_cnt <= CNT_W'(1);
                        state    <= ST_BUSY;
                    end
                end
                default: begin
                    if (!bus.req[last]) begin
                        grant_q <= '0;
                        state   <= ST_IDLE;
                    end else if (MAX_HOLD != 0 && hold_cnt == CNT_W'(MAX_HOLD)) begin
                        // Revoke and mask the holder; the mask survives until it drops req.
                        grant_q          <= '0;
                        timeout_q        <= 1'b1;
                        stall_mask       <= (stall_mask & bus.req) | grant_q;
                        state            <= ST_IDLE;
                    end else if (hold_cnt != {CNT_W{1'b1}}) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.winner_id   = last;
    assign bus.ack_event   = (state == ST_BUSY);
    assign bus.timeout_err = timeout_q;

endmodule
